// File: rtl/calc2_port_responder.sv
// Responder end of one calc2 request port: captures two-cycle requests, queues
// them, executes add/sub/shift in one shared unit and returns tagged responses in order.
module calc2_port_responder #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    input  logic [1:0]        req_tag_in,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_tag,
    output logic              busy,
    output logic              drop_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [1:0]        tag;
    } entry_t;

    typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_t;
    typedef enum logic [1:0] {EX_IDLE, EX_ALU, EX_SHIFT, EX_DONE} ex_state_t;

    cap_state_t        cap_state;
    logic [3:0]        cap_cmd;
    logic [DATA_W-1:0] cap_op1;
    logic [1:0]        cap_tag;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    ex_state_t         ex_state;
    logic [3:0]        ex_cmd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [1:0]        ex_tag;
    logic [4:0]        ex_cnt;
    logic [1:0]        res_resp;
    logic [DATA_W-1:0] res_data;

    logic              push_req;
    entry_t            push_entry;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              bypass;
    logic              push_ok;
    logic              write_en;
    logic              read_en;
    entry_t            head;
    logic [DATA_W:0]   alu_sum;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_data;

    // Capture FSM: cycle 1 latches cmd/op1/tag, cycle 2 supplies op2 straight to the push.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            cap_state <= CAP_IDLE;
            cap_cmd   <= '0;
            cap_op1   <= '0;
            cap_tag   <= '0;
        end else begin
            case (cap_state)
                CAP_IDLE: begin
                    if (req_cmd_in != 4'd0) begin
                        cap_cmd   <= req_cmd_in;
                        cap_op1   <= req_data_in;
                        cap_tag   <= req_tag_in;
                        cap_state <= CAP_OP2;
                    end
                end
                default: cap_state <= CAP_IDLE;
            endcase
        end
    end

    // The head is the incoming entry when the queue is empty, so an idle unit
    // starts on the same edge the request completes without a FIFO round trip.
    always_comb begin
        push_req   = (cap_state == CAP_OP2);
        push_entry = '{cmd: cap_cmd, op1: cap_op1, op2: req_data_in, tag: cap_tag};
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        pop        = (ex_state == EX_IDLE) && (!fifo_empty || push_req);
        bypass     = pop && fifo_empty;
        push_ok    = push_req && (!fifo_full || pop);
        write_en   = push_ok && !bypass;
        read_en    = pop && !fifo_empty;
        head       = fifo_empty ? push_entry : mem[rd_ptr];
    end

    // NOTE: the storage array has no reset; only pointers and count need one,
    // which keeps it mappable onto plain RAM/flop arrays without reset muxes.
    always_ff @(posedge c_clk) begin
        if (write_en) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (read_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({write_en, read_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                drop_err <= 1'b1;
            end
        end
    end

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        alu_sum  = {1'b0, ex_a} + {1'b0, ex_b};
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (ex_cmd)
            CMD_ADD: begin
                if (!alu_sum[DATA_W]) begin
                    alu_resp = RESP_OK;
                    alu_data = alu_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (ex_a >= ex_b) begin
                    alu_resp = RESP_OK;
                    alu_data = ex_a - ex_b;
                end
            end
            default: begin
                alu_resp = RESP_ERR;
                alu_data = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            ex_state <= EX_IDLE;
            ex_cmd   <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_tag   <= '0;
            ex_cnt   <= '0;
            res_resp <= '0;
            res_data <= '0;
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            busy     <= 1'b0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            busy     <= !fifo_empty || (ex_state != EX_IDLE) || pop;
            case (ex_state)
                EX_IDLE: begin
                    if (pop) begin
                        ex_cmd   <= head.cmd;
                        ex_a     <= head.op1;
                        ex_b     <= head.op2;
                        ex_tag   <= head.tag;
                        ex_cnt   <= head.op2[4:0];
                        ex_state <= (head.cmd == CMD_SHL || head.cmd == CMD_SHR)
                                    ? EX_SHIFT : EX_ALU;
                    end
                end
                EX_ALU: begin
                    res_resp <= alu_resp;
                    res_data <= alu_data;
                    ex_state <= EX_DONE;
                end
                EX_SHIFT: begin
                    if (ex_cnt == 5'd0) begin
                        res_resp <= RESP_OK;
                        res_data <= ex_a;
                        ex_state <= EX_DONE;
                    end else begin
                        ex_a   <= (ex_cmd == CMD_SHL) ? (ex_a << 1) : (ex_a >> 1);
                        ex_cnt <= ex_cnt - 5'd1;
                    end
                end
                default: begin
                    out_resp <= res_resp;
                    out_data <= res_data;
                    out_tag  <= ex_tag;
                    ex_state <= EX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc2_port_responder.sv
// Self-checking bench for calc2_port_responder: directed protocol cases plus
// randomized requests scored against an arithmetic reference model.
module tb_calc2_port_responder;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_cmd_in = 4'd0;
    logic [31:0] req_data_in = 32'd0;
    logic [1:0]  req_tag_in = 2'd0;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        busy;
    logic        drop_err;

    int n_assert = 0;
    int n_fail   = 0;

    calc2_port_responder #(.FIFO_DEPTH(4), .DATA_W(32)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .busy        (busy),
        .drop_err    (drop_err)
    );

    initial forever #5 c_clk = ~c_clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Reference result {resp, data} computed from the command rules.
    function automatic logic [33:0] ref_result(input logic [3:0] cmd, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sum;
        int     amt;
        amt = int'(b % 32);
        case (cmd)
            4'd1: begin
                sum = longint'(a) + longint'(b);
                if (sum > longint'(32'hFFFF_FFFF)) return {2'd2, 32'd0};
                return {2'd1, 32'(sum)};
            end
            4'd2: begin
                if (a < b) return {2'd2, 32'd0};
                return {2'd1, a - b};
            end
            4'd5:    return {2'd1, a << amt};
            4'd6:    return {2'd1, a >> amt};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // Edges after E1 until out_* carries the response, with an empty queue.
    function automatic int ref_latency(input logic [3:0] cmd, input logic [31:0] b);
        if (cmd == 4'd5 || cmd == 4'd6) return 2 + int'(b % 32);
        return 2;
    endfunction

    // Two-cycle request; returns 1 time unit after edge E1.
    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] tag, input logic [3:0] cmd2);
        @(negedge c_clk);
        req_cmd_in  = cmd;
        req_data_in = a;
        req_tag_in  = tag;
        @(negedge c_clk);
        req_cmd_in  = cmd2;
        req_data_in = b;
        req_tag_in  = 2'($urandom);
        @(posedge c_clk);
        #1;
        req_cmd_in  = 4'd0;
        req_data_in = $urandom;
    endtask

    // Checks exact latency, the response pulse, and the idle cycle after it.
    task automatic expect_resp(input string name, input logic [3:0] cmd, input logic [31:0] a,
                               input logic [31:0] b, input logic [1:0] tag);
        logic [33:0] exp;
        int          lat;
        logic        early;
        exp   = ref_result(cmd, a, b);
        lat   = ref_latency(cmd, b);
        early = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(posedge c_clk);
            #1;
            if (k < lat && out_resp != 2'd0) early = 1'b1;
        end
        check({name, "_early"}, 64'(early), 64'd0);
        check({name, "_resp"}, 64'(out_resp), 64'(exp[33:32]));
        check({name, "_data"}, 64'(out_data), 64'(exp[31:0]));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        @(posedge c_clk);
        #1;
        check({name, "_after"}, 64'({out_resp, out_data, out_tag}), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    logic [35:0] exp_q[$];
    logic [35:0] e;
    logic [3:0]  cmd_tab [8] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd3, 4'd12};
    logic [1:0]  tag_tab [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0]  rc;
    logic [31:0] ra, rb;
    logic [1:0]  rt;
    logic        flag;

    initial begin
        // Reset state
        #1 reset = 1'b1;
        repeat (3) @(posedge c_clk);
        #1;
        check("rst_out", 64'({out_resp, out_data, out_tag}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop_err), 64'd0);
        @(negedge c_clk);
        reset = 1'b0;

        // Basic add and error cases
        send(4'd1, 32'h30, 32'h20, 2'd1, 4'd0);
        expect_resp("add", 4'd1, 32'h30, 32'h20, 2'd1);
        send(4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 4'd0);
        expect_resp("add_carry", 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2);
        send(4'd2, 32'h10, 32'h20, 2'd3, 4'd0);
        expect_resp("sub_neg", 4'd2, 32'h10, 32'h20, 2'd3);
        send(4'd2, 32'h20, 32'h10, 2'd0, 4'd0);
        expect_resp("sub_ok", 4'd2, 32'h20, 32'h10, 2'd0);
        send(4'd3, 32'h7, 32'h9, 2'd1, 4'd0);
        expect_resp("inv_cmd", 4'd3, 32'h7, 32'h9, 2'd1);

        // Shift corners
        send(4'd5, 32'h1, 32'd4, 2'd2, 4'd0);
        expect_resp("shl4", 4'd5, 32'h1, 32'd4, 2'd2);
        send(4'd6, 32'h8000_0000, 32'd31, 2'd3, 4'd0);
        expect_resp("shr31", 4'd6, 32'h8000_0000, 32'd31, 2'd3);
        send(4'd5, 32'h1, 32'h25, 2'd0, 4'd0);
        expect_resp("shl_wrap", 4'd5, 32'h1, 32'h25, 2'd0);
        send(4'd6, 32'hDEAD_BEEF, 32'h0, 2'd1, 4'd0);
        expect_resp("shr0", 4'd6, 32'hDEAD_BEEF, 32'h0, 2'd1);

        // Randomized requests
        for (int i = 0; i < 24; i++) begin
            rc = cmd_tab[$urandom_range(0, 7)];
            ra = $urandom;
            rb = $urandom;
            rt = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                ra = ra >> 1;
                rb = rb >> 1;
            end
            if (rc == 4'd5 || rc == 4'd6) rb = rb & 32'hFFFF_FFEF;
            send(rc, ra, rb, rt, 4'd0);
            expect_resp("rand", rc, ra, rb, rt);
        end

        // Queue fill behind a long shift, last request dropped
        send(4'd5, 32'h3, 32'd31, 2'd0, 4'd0);
        check("q4_busy", 64'(busy), 64'd1);
        exp_q.push_back({2'd0, ref_result(4'd5, 32'h3, 32'd31)});
        for (int i = 0; i < 5; i++) begin
            send(4'd1, 32'h1, 32'h1, tag_tab[i], 4'd0);
            if (i < 4) exp_q.push_back({tag_tab[i], ref_result(4'd1, 32'h1, 32'h1)});
            if (i == 3) check("q4_no_drop", 64'(drop_err), 64'd0);
            if (i == 4) check("q4_drop", 64'(drop_err), 64'd1);
        end
        for (int c = 0; c < 120; c++) begin
            @(posedge c_clk);
            #1;
            if (out_resp != 2'd0) begin
                if (exp_q.size() == 0) begin
                    check("q4_extra", 64'(out_resp), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("q4_order", 64'({out_tag, out_resp, out_data}), 64'(e));
                end
            end
        end
        check("q4_pending", 64'(exp_q.size()), 64'd0);
        check("q4_idle", 64'(busy), 64'd0);
        check("q4_sticky", 64'(drop_err), 64'd1);

        // Reset in the middle of a shift
        send(4'd5, 32'h1, 32'd20, 2'd2, 4'd0);
        repeat (9) @(posedge c_clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out", 64'({out_resp, out_data, out_tag}), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_drop", 64'(drop_err), 64'd0);
        @(negedge c_clk);
        reset = 1'b0;
        flag = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge c_clk);
            #1;
            if (out_resp != 2'd0 || busy) flag = 1'b1;
        end
        check("mid_rst_silent", 64'(flag), 64'd0);
        send(4'd1, 32'h5, 32'h6, 2'd3, 4'd0);
        expect_resp("post_rst_add", 4'd1, 32'h5, 32'h6, 2'd3);
        check("post_rst_drop", 64'(drop_err), 64'd0);

        // Idle bus with noisy data, then cmd ignored in the op2 cycle
        flag = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge c_clk);
            req_cmd_in  = 4'd0;
            req_data_in = $urandom;
            @(posedge c_clk);
            #1;
            if (out_resp != 2'd0 || busy) flag = 1'b1;
        end
        check("idle_quiet", 64'(flag), 64'd0);
        send(4'd1, 32'h11, 32'h22, 2'd1, 4'd2);
        expect_resp("op2_cmd_ignored", 4'd1, 32'h11, 32'h22, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
